// File: rtl/flash_programmer_pkg.sv
// Shared command words, status-register bit positions, state encodings and
// command-list helpers for the flash write engine.
package flash_programmer_pkg;

  localparam logic [15:0] FlashCmdReadArray   = 16'h00FF;
  localparam logic [15:0] FlashCmdProgram     = 16'h0040;
  localparam logic [15:0] FlashCmdErase       = 16'h0020;
  localparam logic [15:0] FlashCmdConfirm     = 16'h00D0;
  localparam logic [15:0] FlashCmdUnlock      = 16'h0060;
  localparam logic [15:0] FlashCmdReadStatus  = 16'h0070;
  localparam logic [15:0] FlashCmdClearStatus = 16'h0050;

  localparam int SrReady    = 7;
  localparam int SrEraseErr = 5;
  localparam int SrProgErr  = 4;
  localparam int SrVppErr   = 3;
  localparam int SrLockErr  = 1;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_CMD, ST_POLL_RD, ST_CHECK, ST_DONE
  } prog_state_e;

  typedef enum logic [2:0] {
    BUS_IDLE, BUS_SETUP, BUS_WE, BUS_HOLD, BUS_RD, BUS_REC
  } bus_phase_e;

  typedef enum logic {OP_PROG, OP_ERASE} op_e;

  // Erase list starts with unlock (60/D0) before the block erase (20/D0).
  function automatic logic [15:0] cmd_word(op_e op, logic [2:0] step, logic [15:0] wdata);
    logic [15:0] w;
    w = FlashCmdReadStatus;
    if (op == OP_PROG) begin
      case (step)
        3'd0:    w = FlashCmdProgram;
        3'd1:    w = wdata;
        default: w = FlashCmdReadStatus;
      endcase
    end else begin
      case (step)
        3'd0:    w = FlashCmdUnlock;
        3'd1:    w = FlashCmdConfirm;
        3'd2:    w = FlashCmdErase;
        3'd3:    w = FlashCmdConfirm;
        default: w = FlashCmdReadStatus;
      endcase
    end
    return w;
  endfunction

  function automatic logic [2:0] last_step(op_e op);
    return (op == OP_PROG) ? 3'd2 : 3'd4;
  endfunction

  function automatic logic sr_error(logic [7:0] sr);
    return sr[SrEraseErr] | sr[SrProgErr] | sr[SrVppErr] | sr[SrLockErr];
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// Executes one flash bus write or status read; accepts a new start in its
// final cycle so accesses run back to back.
module flash_bus_cycle
  import flash_programmer_pkg::*;
#(
  parameter int WE_CYC = 3,
  parameter int RD_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        write,
  input  logic [15:0] wdata,
  input  logic [7:0]  rd_in,
  output logic        ce,
  output logic        oe,
  output logic        we,
  output logic        data_oe,
  output logic [15:0] data_out,
  output logic [7:0]  rd_data,
  output logic        cycle_done,
  output logic        idle,
  output bus_phase_e  phase
);

  bus_phase_e  phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  rd_q, rd_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= BUS_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rd_q    <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rd_d    = rd_q;
    case (phase_q)
      BUS_IDLE, BUS_HOLD, BUS_REC: begin
        phase_d = BUS_IDLE;
        if (start) begin
          phase_d = write ? BUS_SETUP : BUS_RD;
          cnt_d   = '0;
          if (write) data_d = wdata;
        end
      end
      BUS_SETUP: begin
        phase_d = BUS_WE;
        cnt_d   = '0;
      end
      BUS_WE: begin
        if (cnt_q == 8'(WE_CYC - 1)) phase_d = BUS_HOLD;
        else                         cnt_d   = cnt_q + 8'd1;
      end
      BUS_RD: begin
        // Status is sampled at the end of the last oe-low cycle.
        if (cnt_q == 8'(RD_CYC - 1)) begin
          phase_d = BUS_REC;
          rd_d    = rd_in;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: phase_d = BUS_IDLE;
    endcase
  end

  assign ce         = !(phase_q inside {BUS_SETUP, BUS_WE, BUS_HOLD, BUS_RD});
  assign oe         = (phase_q != BUS_RD);
  assign we         = (phase_q != BUS_WE);
  assign data_oe    = (phase_q inside {BUS_SETUP, BUS_WE, BUS_HOLD});
  assign data_out   = data_q;
  assign rd_data    = rd_q;
  assign cycle_done = (phase_q == BUS_HOLD) || (phase_q == BUS_REC);
  assign idle       = (phase_q == BUS_IDLE);
  assign phase      = phase_q;

endmodule

// File: rtl/flash_programmer.sv
// Program/block-erase engine for an Intel-command-set flash; always leaves the
// device in read-array mode after an operation.
module flash_programmer
  import flash_programmer_pkg::*;
#(
  parameter int WE_CYC     = 3,
  parameter int RD_CYC     = 3,
  parameter int POLL_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_req,
  input  logic        erase_req,
  input  logic [21:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  status_out,
  output logic [22:0] flash_addr,
  inout  wire  [15:0] flash_data,
  output logic        flash_byte,
  output logic        flash_vpen,
  output logic        flash_rp,
  output logic        flash_ce,
  output logic        flash_oe,
  output logic        flash_we,
  output prog_state_e dbg_state,
  output bus_phase_e  dbg_bus_phase
);

  prog_state_e state_q, state_d;
  op_e         op_q, op_d;
  logic [2:0]  step_q;
  logic [21:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] poll_q, poll_next;
  logic        error_q;
  logic [7:0]  status_q;

  logic        bus_start, bus_write, bus_data_oe, bus_done, bus_idle;
  logic [15:0] bus_wdata, bus_data_out;
  logic [7:0]  bus_rd;
  logic        accept, step_clr, step_inc, poll_inc, sr_load, more_polls;

  flash_bus_cycle #(.WE_CYC(WE_CYC), .RD_CYC(RD_CYC)) u_bus (
    .clk(clk), .rst(rst), .start(bus_start), .write(bus_write), .wdata(bus_wdata),
    .rd_in(flash_data[7:0]), .ce(flash_ce), .oe(flash_oe), .we(flash_we),
    .data_oe(bus_data_oe), .data_out(bus_data_out), .rd_data(bus_rd),
    .cycle_done(bus_done), .idle(bus_idle), .phase(dbg_bus_phase)
  );

  assign poll_next  = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
  assign more_polls = !bus_rd[SrReady] && (poll_next < 16'(POLL_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  // Each new access is started in the final cycle of the previous one.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    bus_start = 1'b0;
    bus_write = 1'b1;
    bus_wdata = FlashCmdReadArray;
    accept    = 1'b0;
    step_clr  = 1'b0;
    step_inc  = 1'b0;
    poll_inc  = 1'b0;
    sr_load   = 1'b0;
    case (state_q)
      ST_INIT: begin
        bus_start = bus_idle;
        if (bus_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (prog_req || erase_req) begin
          accept    = 1'b1;
          op_d      = erase_req ? OP_ERASE : OP_PROG;
          bus_start = 1'b1;
          bus_wdata = cmd_word(op_d, 3'd0, wdata);
          state_d   = ST_CMD;
        end
      end
      ST_CMD: begin
        if (bus_done) begin
          bus_start = 1'b1;
          if (step_q == last_step(op_q)) begin
            bus_write = 1'b0;
            state_d   = ST_POLL_RD;
          end else begin
            bus_wdata = cmd_word(op_q, step_q + 3'd1, wdata_q);
            step_inc  = 1'b1;
          end
        end
      end
      ST_POLL_RD: begin
        if (bus_done) begin
          bus_start = 1'b1;
          poll_inc  = 1'b1;
          if (more_polls) begin
            bus_write = 1'b0;
          end else begin
            sr_load   = 1'b1;
            step_clr  = 1'b1;
            bus_wdata = FlashCmdClearStatus;
            state_d   = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (bus_done) begin
          if (step_q == 3'd0) begin
            bus_start = 1'b1;
            bus_wdata = FlashCmdReadArray;
            step_inc  = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_PROG;
      step_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      poll_q   <= '0;
      error_q  <= 1'b0;
      status_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_d;
        step_q  <= '0;
        poll_q  <= '0;
        error_q <= 1'b0;
        addr_q  <= erase_req ? {addr[21:16], 16'h0000} : addr;
        wdata_q <= wdata;
      end
      if (step_clr)      step_q <= '0;
      else if (step_inc) step_q <= step_q + 3'd1;
      if (poll_inc) poll_q <= poll_next;
      // A read that is still not ready here means the poll budget ran out.
      if (sr_load) begin
        status_q <= bus_rd[SrReady] ? bus_rd : 8'hFF;
        error_q  <= !bus_rd[SrReady] || sr_error(bus_rd);
      end
    end
  end

  assign flash_data = bus_data_oe ? bus_data_out : 16'hzzzz;
  assign flash_addr = {addr_q, 1'b0};
  assign flash_byte = 1'b1;
  assign flash_vpen = 1'b1;
  assign flash_rp   = 1'b1;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign error      = error_q;
  assign status_out = status_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_flash_programmer.sv
// Directed bench for flash_programmer: a status-register flash model, a write
// log checked against hand-written command lists, and timing/reset sequences.
module tb_flash_programmer;
  import flash_programmer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_req = 1'b0, erase_req = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        busy, done, error;
  logic [7:0]  status_out;
  logic [22:0] flash_addr;
  wire  [15:0] flash_data;
  logic        flash_byte, flash_vpen, flash_rp, flash_ce, flash_oe, flash_we;
  prog_state_e dbg_state;
  bus_phase_e  dbg_bus_phase;

  flash_programmer #(.WE_CYC(3), .RD_CYC(3), .POLL_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .prog_req(prog_req), .erase_req(erase_req),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .error(error),
    .status_out(status_out), .flash_addr(flash_addr), .flash_data(flash_data),
    .flash_byte(flash_byte), .flash_vpen(flash_vpen), .flash_rp(flash_rp),
    .flash_ce(flash_ce), .flash_oe(flash_oe), .flash_we(flash_we),
    .dbg_state(dbg_state), .dbg_bus_phase(dbg_bus_phase)
  );

  // clock / reset-free clock generation
  always #5 clk = ~clk;

  // flash model: status reads return 0x00 until the ready_after-th read
  int          rd_total = 0, rd_base = 0, ready_after = 1;
  logic [7:0]  sr_final = 8'h80;
  logic [7:0]  model_sr;
  assign model_sr   = ((rd_total - rd_base + 1) >= ready_after) ? sr_final : 8'h00;
  assign flash_data = (!flash_ce && !flash_oe) ? {8'h00, model_sr} : 16'hzzzz;

  // bus monitor: log each write at the rising edge of we, count reads
  logic [38:0] wr_log[$];
  logic        prev_we = 1'b1, prev_oe = 1'b1;
  int          viol = 0;
  always @(negedge clk) begin
    if (!prev_we && flash_we) wr_log.push_back({flash_addr, flash_data});
    if (!prev_oe && flash_oe) rd_total++;
    if (!flash_ce && !flash_oe && !flash_we) viol++;
    if (!flash_oe && dut.bus_data_oe) viol++;
    prev_we = flash_we;
    prev_oe = flash_oe;
  end

  int checks = 0, errors = 0;
  logic [38:0] exp_q[$];

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_erase;
    logic        both;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [7:0]  sr;
    int          ready_after;
    logic [22:0] exp_faddr;
    logic        exp_err;
    logic [7:0]  exp_status;
    int          exp_cycles;
    int          exp_reads;
  } vec_t;

  vec_t vecs[8];

  // compare the scoreboard queue against writes logged since wb
  task automatic check_writes(input string tag, input int wb);
    check_val({tag, "_wr_count"}, 64'(wr_log.size() - wb), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (wb + k < wr_log.size())
        check_val($sformatf("%s_wr%0d", tag, k), 64'(wr_log[wb + k]), 64'(exp_q[k]));
    end
  endtask

  task automatic check_init(input string tag);
    int   n;
    int   ce_at;
    logic saw_done;
    int   wb;
    ce_at = -1;
    saw_done = 1'b0;
    wb = wr_log.size();
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (ce_at < 0 && !flash_ce) ce_at = n;
      if (ce_at >= 0 && !busy) break;
    end
    check_val({tag, "_busy_fall"}, 64'(n - ce_at), 64'd5);
    check_val({tag, "_no_done"}, 64'(saw_done), 64'd0);
    exp_q.delete();
    exp_q.push_back({23'h000000, 16'h00FF});
    check_writes(tag, wb);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   cyc;
    int   wb;
    string tag;
    v   = vecs[i];
    tag = $sformatf("v%0d", i);
    exp_q.delete();
    if (v.is_erase) begin
      exp_q.push_back({v.exp_faddr, 16'h0060});
      exp_q.push_back({v.exp_faddr, 16'h00D0});
      exp_q.push_back({v.exp_faddr, 16'h0020});
      exp_q.push_back({v.exp_faddr, 16'h00D0});
    end else begin
      exp_q.push_back({v.exp_faddr, 16'h0040});
      exp_q.push_back({v.exp_faddr, v.wdata});
    end
    exp_q.push_back({v.exp_faddr, 16'h0070});
    exp_q.push_back({v.exp_faddr, 16'h0050});
    exp_q.push_back({v.exp_faddr, 16'h00FF});

    @(negedge clk);
    rd_base     = rd_total;
    wb          = wr_log.size();
    sr_final    = v.sr;
    ready_after = v.ready_after;
    addr        = v.addr;
    wdata       = v.wdata;
    erase_req   = v.is_erase;
    prog_req    = !v.is_erase || v.both;
    @(negedge clk);
    prog_req  = 1'b0;
    erase_req = 1'b0;
    check_val({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      // a request while busy must be ignored
      if (cyc == 10)      prog_req = 1'b1;
      else if (cyc == 11) prog_req = 1'b0;
    end
    prog_req = 1'b0;
    check_val({tag, "_cycles"}, 64'(cyc), 64'(v.exp_cycles));
    check_val({tag, "_error"}, 64'(error), 64'(v.exp_err));
    check_val({tag, "_status"}, 64'(status_out), 64'(v.exp_status));
    check_val({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check_val({tag, "_reads"}, 64'(rd_total - rd_base), 64'(v.exp_reads));
    @(negedge clk);
    check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_val({tag, "_status_hold"}, 64'(status_out), 64'(v.exp_status));
    check_writes(tag, wb);
  endtask

  initial begin
    //          erase both  addr        wdata     sr     rdy faddr        err st     cyc reads
    vecs[0] = '{1'b0, 1'b0, 22'h000123, 16'hBEEF, 8'h80, 1, 23'h000246, 1'b0, 8'h80, 29, 1};
    vecs[1] = '{1'b1, 1'b0, 22'h012345, 16'h0000, 8'h80, 4, 23'h020000, 1'b0, 8'h80, 51, 4};
    vecs[2] = '{1'b0, 1'b0, 22'h3FFFFF, 16'h0000, 8'h90, 1, 23'h7FFFFE, 1'b1, 8'h90, 29, 1};
    vecs[3] = '{1'b0, 1'b0, 22'h000001, 16'h1234, 8'h80, 9, 23'h000002, 1'b1, 8'hFF, 57, 8};
    vecs[4] = '{1'b1, 1'b0, 22'h3FFFFF, 16'h0000, 8'hA0, 2, 23'h7E0000, 1'b1, 8'hA0, 43, 2};
    vecs[5] = '{1'b0, 1'b0, 22'h2AAAAA, 16'h5555, 8'h88, 8, 23'h555554, 1'b1, 8'h88, 57, 8};
    vecs[6] = '{1'b0, 1'b0, 22'h000010, 16'hA5A5, 8'h82, 1, 23'h000020, 1'b1, 8'h82, 29, 1};
    vecs[7] = '{1'b1, 1'b1, 22'h00FFFF, 16'hFFFF, 8'hC0, 1, 23'h000000, 1'b0, 8'hC0, 39, 1};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ce", 64'(flash_ce), 64'd1);
    check_val("rst_oe", 64'(flash_oe), 64'd1);
    check_val("rst_we", 64'(flash_we), 64'd1);
    check_val("rst_data_z", 64'(dut.bus_data_oe), 64'd0);
    check_val("rst_addr", 64'(flash_addr), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd1);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_error", 64'(error), 64'd0);
    check_val("rst_status", 64'(status_out), 64'd0);
    check_val("const_pins", 64'({flash_byte, flash_vpen, flash_rp}), 64'b111);
    rst = 1'b1;
    check_init("init");

    for (int i = 0; i < 8; i++) run_vec(i);

    // reset asserted while an erase write strobe is low
    @(negedge clk);
    addr = 22'h012345;
    erase_req = 1'b1;
    @(negedge clk);
    erase_req = 1'b0;
    begin
      int w;
      for (w = 0; w < 20 && flash_we; w++) @(negedge clk);
      check_val("midrst_we_low_seen", 64'(flash_we), 64'd0);
    end
    #2 rst = 1'b0;
    #1;
    check_val("midrst_ce", 64'(flash_ce), 64'd1);
    check_val("midrst_oe", 64'(flash_oe), 64'd1);
    check_val("midrst_we", 64'(flash_we), 64'd1);
    check_val("midrst_data_z", 64'(dut.bus_data_oe), 64'd0);
    check_val("midrst_busy", 64'(busy), 64'd1);
    check_val("midrst_addr", 64'(flash_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_init("post_rst");
    run_vec(0);

    check_val("bus_protocol_violations", 64'(viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
